// File: rtl/savestate_ctrl.sv
// Save/load sequencer: pauses the core, launches a DDR state stream for one slot, releases the core.
// Latency: pause_req one cycle after the accepted edge, start strobe two cycles after pause_ack; no backpressure, busy edges dropped.
module savestate_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h3E00_0000,
    parameter logic [31:0] SLOT_SIZE      = 32'h0040_0000,
    parameter logic [15:0] PAUSE_TIMEOUT  = 16'd1000,
    parameter logic [3:0]  LAUNCH_TIMEOUT = 4'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        save_req,
    input  logic        load_req,
    input  logic [1:0]  slot,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        pause_req,
    input  logic        pause_ack,
    output logic [31:0] start_addr,
    output logic [31:0] length,
    output logic        write_start,
    output logic        read_start,
    input  logic        stream_busy
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PAUSE_WAIT = 3'd1,
        START      = 3'd2,
        LAUNCH     = 3'd3,
        RUN        = 3'd4,
        RELEASE    = 3'd5,
        DONE       = 3'd6
    } state_t;

    localparam logic [15:0] PAUSE_LAST  = PAUSE_TIMEOUT - 16'd1;
    localparam logic [15:0] LAUNCH_LAST = {12'd0, LAUNCH_TIMEOUT} - 16'd1;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        fail_q, fail_d;
    logic        op_save_q, op_save_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        pause_req_q, pause_req_d;
    logic        write_start_q, write_start_d;
    logic        read_start_q, read_start_d;
    logic [31:0] start_addr_q, start_addr_d;
    logic [31:0] length_q, length_d;
    // Arm flags record "request was low last cycle"; clearing them in reset
    // keeps a request held through reset from firing until it toggles.
    logic        save_arm_q, save_arm_d;
    logic        load_arm_q, load_arm_d;

    logic        save_edge;
    logic        load_edge;
    logic [31:0] slot_offset;

    assign save_edge   = save_req & save_arm_q;
    assign load_edge   = load_req & load_arm_q;
    assign slot_offset = {30'd0, slot} * SLOT_SIZE;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        fail_d        = fail_q;
        op_save_d     = op_save_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        pause_req_d   = pause_req_q;
        write_start_d = 1'b0;
        read_start_d  = 1'b0;
        start_addr_d  = start_addr_q;
        length_d      = length_q;
        save_arm_d    = ~save_req;
        load_arm_d    = ~load_req;

        case (state_q)
            IDLE: begin
                if (save_edge || load_edge) begin
                    op_save_d    = save_edge;
                    start_addr_d = BASE_ADDR + slot_offset;
                    length_d     = SLOT_SIZE;
                    pause_req_d  = 1'b1;
                    timer_d      = 16'd0;
                    busy_d       = 1'b1;
                    state_d      = PAUSE_WAIT;
                end
            end
            PAUSE_WAIT: begin
                if (pause_ack) begin
                    state_d = START;
                end else if (timer_q == PAUSE_LAST) begin
                    fail_d      = 1'b1;
                    pause_req_d = 1'b0;
                    state_d     = RELEASE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            START: begin
                write_start_d = op_save_q;
                read_start_d  = ~op_save_q;
                timer_d       = 16'd0;
                state_d       = LAUNCH;
            end
            LAUNCH: begin
                if (stream_busy) begin
                    state_d = RUN;
                end else if (timer_q == LAUNCH_LAST) begin
                    fail_d      = 1'b1;
                    pause_req_d = 1'b0;
                    state_d     = RELEASE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            RUN: begin
                if (!stream_busy) begin
                    pause_req_d = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                pause_req_d = 1'b0;
                if (!pause_ack) begin
                    done_d  = 1'b1;
                    error_d = fail_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                fail_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= 16'd0;
            fail_q        <= 1'b0;
            op_save_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            pause_req_q   <= 1'b0;
            write_start_q <= 1'b0;
            read_start_q  <= 1'b0;
            start_addr_q  <= 32'd0;
            length_q      <= 32'd0;
            save_arm_q    <= 1'b0;
            load_arm_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            fail_q        <= fail_d;
            op_save_q     <= op_save_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            pause_req_q   <= pause_req_d;
            write_start_q <= write_start_d;
            read_start_q  <= read_start_d;
            start_addr_q  <= start_addr_d;
            length_q      <= length_d;
            save_arm_q    <= save_arm_d;
            load_arm_q    <= load_arm_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign pause_req   = pause_req_q;
    assign write_start = write_start_q;
    assign read_start  = read_start_q;
    assign start_addr  = start_addr_q;
    assign length      = length_q;

    a_one_strobe: assert property (@(posedge clk) disable iff (reset)
        !(write_start_q && read_start_q));
    a_error_with_done: assert property (@(posedge clk) disable iff (reset)
        error_q |-> done_q);

endmodule

// File: tb/tb_savestate_ctrl.sv
// Directed bench for savestate_ctrl: core/stream responders, expected completions queued per command,
// a monitor compares each done pulse against the queue head.
module tb_savestate_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        save_req;
    logic        load_req;
    logic [1:0]  slot;
    logic        busy, done, error, pause_req;
    logic        pause_ack;
    logic [31:0] start_addr, length;
    logic        write_start, read_start;
    logic        stream_busy;

    savestate_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .save_req    (save_req),
        .load_req    (load_req),
        .slot        (slot),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .pause_req   (pause_req),
        .pause_ack   (pause_ack),
        .start_addr  (start_addr),
        .length      (length),
        .write_start (write_start),
        .read_start  (read_start),
        .stream_busy (stream_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        int          wr;
        int          rd;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int strobe_cyc = 0;
    int ack_rise_cyc = 0;

    int ack_delay   = 3;
    bit ack_never   = 1'b0;
    int stream_len  = 20;
    bit stream_never = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic err, input int wr, input int rd, input logic [31:0] addr);
        exp_t e;
        e.err  = err;
        e.wr   = wr;
        e.rd   = rd;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        check(name, done_cnt, d0 + 1);
        repeat (3) @(negedge clk);
    endtask

    // Core responder: acks pause after ack_delay cycles, drops ack once pause_req falls.
    int ack_cnt = 0;
    initial begin
        pause_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!pause_req) begin
                pause_ack = 1'b0;
                ack_cnt   = 0;
            end else if (!pause_ack && !ack_never) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    pause_ack    = 1'b1;
                    ack_rise_cyc = cyc;
                end
            end
        end
    end

    // Stream responder: busy for stream_len cycles after any start strobe.
    int str_cnt = 0;
    initial begin
        stream_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (str_cnt > 0) begin
                str_cnt--;
                if (str_cnt == 0) stream_busy = 1'b0;
            end else if ((write_start || read_start) && !stream_never) begin
                str_cnt     = stream_len;
                stream_busy = 1'b1;
            end
        end
    end

    // Monitor: every done pulse is matched against the oldest expected completion.
    bit after_done = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (after_done) begin
                after_done = 1'b0;
                check("done_width", {31'd0, done}, 32'd0);
                check("busy_after_done", {31'd0, busy}, 32'd0);
            end
            if (reset) begin
                wr_cnt = 0;
                rd_cnt = 0;
            end else begin
                if (write_start) begin wr_cnt++; strobe_cyc = cyc; end
                if (read_start)  begin rd_cnt++; strobe_cyc = cyc; end
                if (done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_error", {31'd0, error}, {31'd0, e.err});
                        check("write_strobes", wr_cnt, e.wr);
                        check("read_strobes", rd_cnt, e.rd);
                        check("start_addr", start_addr, e.addr);
                        check("length", length, 32'h0040_0000);
                        check("busy_at_done", {31'd0, busy}, 32'd1);
                    end
                    wr_cnt = 0;
                    rd_cnt = 0;
                    after_done = 1'b1;
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cyc, r_cyc, cnt, d0;

        reset    = 1'b1;
        save_req = 1'b1;
        load_req = 1'b0;
        slot     = 2'd0;
        repeat (4) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_pause_req", {31'd0, pause_req}, 32'd0);
        check("rst_strobes", {30'd0, write_start, read_start}, 32'd0);
        check("rst_start_addr", start_addr, 32'd0);
        check("rst_length", length, 32'd0);

        // Request held through reset must not fire.
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("held_req_busy", {31'd0, busy}, 32'd0);
        check("held_req_pause", {31'd0, pause_req}, 32'd0);
        save_req = 1'b0;
        repeat (3) @(negedge clk);

        // Save slot 2, ack after 3 cycles, stream 20 cycles.
        ack_delay = 3; stream_len = 20;
        push_exp(1'b0, 1, 0, 32'h3E80_0000);
        slot = 2'd2; save_req = 1'b1;
        @(negedge clk);
        check("accept_pause_req", {31'd0, pause_req}, 32'd1);
        check("accept_busy", {31'd0, busy}, 32'd1);
        save_req = 1'b0;
        wait_done("save_slot2_done");
        check("ack_to_strobe", strobe_cyc - ack_rise_cyc, 32'd2);

        // Load slot 0.
        ack_delay = 1; stream_len = 5;
        push_exp(1'b0, 0, 1, 32'h3E00_0000);
        slot = 2'd0; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        wait_done("load_slot0_done");

        // Pause never acknowledged: pause_req held exactly 1000 cycles.
        ack_never = 1'b1;
        push_exp(1'b1, 0, 0, 32'h3E40_0000);
        slot = 2'd1; save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        cnt = 0;
        while (pause_req && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        check("pause_timeout_cycles", cnt, 32'd1000);
        wait_done("pause_timeout_done");
        ack_never = 1'b0;

        // Stream never starts: pause_req drops 8 cycles after the strobe.
        stream_never = 1'b1; ack_delay = 2;
        push_exp(1'b1, 1, 0, 32'h3EC0_0000);
        slot = 2'd3; save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        s_cyc = 0;
        for (int i = 0; i < 50 && !write_start; i++) @(negedge clk);
        s_cyc = cyc;
        for (int i = 0; i < 50 && pause_req; i++) @(negedge clk);
        r_cyc = cyc;
        check("launch_timeout_cycles", r_cyc - s_cyc, 32'd8);
        wait_done("launch_timeout_done");
        stream_never = 1'b0;

        // Simultaneous edges: save wins; a re-pulse during RUN is dropped.
        ack_delay = 2; stream_len = 15;
        d0 = done_cnt;
        push_exp(1'b0, 1, 0, 32'h3E40_0000);
        slot = 2'd1; save_req = 1'b1; load_req = 1'b1;
        repeat (3) @(negedge clk);
        save_req = 1'b0; load_req = 1'b0;
        for (int i = 0; i < 50 && !stream_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        slot = 2'd3; save_req = 1'b1;
        repeat (2) @(negedge clk);
        save_req = 1'b0;
        wait_done("collide_done");
        repeat (10) @(negedge clk);
        check("collide_done_count", done_cnt, d0 + 1);
        check("collide_idle", {31'd0, busy}, 32'd0);

        // Reset during RUN: pause_req and busy drop next cycle, no done.
        ack_delay = 1; stream_len = 30;
        d0 = done_cnt;
        slot = 2'd0; save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        for (int i = 0; i < 50 && !stream_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("run_busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_run_pause_req", {31'd0, pause_req}, 32'd0);
        check("reset_run_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100 && stream_busy; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("reset_run_no_done", done_cnt, d0);

        // Normal load after the reset.
        ack_delay = 2; stream_len = 4;
        push_exp(1'b0, 0, 1, 32'h3EC0_0000);
        slot = 2'd3; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        wait_done("post_reset_load_done");

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/savestate_ctrl.md
SAVESTATE_CTRL -- requirements
Module: savestate_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3E00_0000, DDR byte address of slot 0.
REQ-002 Parameter SLOT_SIZE, default 32'h0040_0000, bytes per slot; also the stream length.
REQ-003 Parameter PAUSE_TIMEOUT, default 16'd1000, max cycles to wait for pause_ack.
REQ-004 Parameter LAUNCH_TIMEOUT, default 4'd8, max cycles to wait for stream_busy after a start strobe.
REQ-005 clk  in  1  sole clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 save_req  in  1  save command; rising edge detected.
REQ-008 load_req  in  1  load command; rising edge detected.
REQ-009 slot  in  2  slot index, sampled with the accepted command.
REQ-010 busy  out  1  high from command accept until the DONE state is left.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 error  out  1  one-cycle pulse coincident with done on a failed operation.
REQ-013 pause_req  out  1  level request for the core to halt.
REQ-014 pause_ack  in  1  core is halted.
REQ-015 start_addr  out  32  stream start address.
REQ-016 length  out  32  stream byte length.
REQ-017 write_start  out  1  one-cycle strobe; stream gathers state to DDR (save).
REQ-018 read_start  out  1  one-cycle strobe; stream scatters state from DDR (load).
REQ-019 stream_busy  in  1  stream engine is active.

Function
REQ-020 States SHALL be IDLE, PAUSE_WAIT, START, LAUNCH, RUN, RELEASE, DONE.
REQ-021 Edge detectors SHALL register save_req and load_req every cycle, in every state.
REQ-022 IDLE: a save edge SHALL win over a simultaneous load edge; the losing edge is discarded.
REQ-023 On accept: latch op and slot, start_addr <= BASE_ADDR + slot*SLOT_SIZE (32-bit, truncated), length <= SLOT_SIZE, pause_req <= 1, clear timer, busy <= 1, go PAUSE_WAIT.
REQ-024 Edges arriving while busy SHALL be ignored and not queued.
REQ-025 PAUSE_WAIT: pause_ack=1 -> START. Otherwise timer increments; when timer reaches PAUSE_TIMEOUT-1 -> set fail flag, go RELEASE.
REQ-026 START: for exactly one cycle, assert write_start (save) or read_start (load), never both; clear timer; go LAUNCH.
REQ-027 LAUNCH: stream_busy=1 -> RUN. Otherwise timer increments; when timer reaches LAUNCH_TIMEOUT-1 -> set fail flag, go RELEASE.
REQ-028 RUN: remain until stream_busy=0, then go RELEASE; RUN has no timeout.
REQ-029 RELEASE: pause_req <= 0; wait for pause_ack=0, then go DONE.
REQ-030 DONE: done=1 and error=fail flag for one cycle; busy <= 0; clear fail flag; go IDLE.
REQ-031 start_addr and length SHALL hold their values from accept until the next accept.
REQ-032 Latency: accept edge -> pause_req high on the next cycle; pause_ack high -> start strobe 2 cycles later.

Reset
REQ-033 Reset SHALL force IDLE and clear busy, done, error, pause_req, write_start, read_start, the timer, the fail flag, the edge registers, start_addr and length to 0.
REQ-034 Reset mid-operation SHALL take effect on the next edge, dropping pause_req. The stream engine is not aborted by this block.
REQ-035 A request held high through reset SHALL NOT trigger until it falls and rises again.

Verification
REQ-036 Save, slot 2, pause_ack 3 cycles after pause_req, stream_busy for 20 cycles -> write_start pulses once, start_addr=32'h3E80_0000, length=32'h0040_0000; done pulses with error=0.
REQ-037 Load, slot 0 -> read_start pulses and write_start stays 0; start_addr=32'h3E00_0000.
REQ-038 pause_ack never rises -> after 1000 cycles pause_req drops, no start strobe, done=error=1 for one cycle.
REQ-039 stream_busy never rises after the strobe -> error after 8 cycles in LAUNCH; pause_req released.
REQ-040 save_req and load_req rise together, then save_req re-pulses during RUN -> save is executed once only; exactly one done.
REQ-041 Reset asserted during RUN -> pause_req=0 and busy=0 next cycle; no done pulse.
